// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed 7-segment scan driver (common anode, active-low pins).
// Scans slots 5..0 round-robin. Each slot opens with a blanking gap, and the
// six digits are latched once per frame.
// Optional build macro: SEG_LZ_BLANK_EN enables leading-zero suppression.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500,
  parameter logic [5:0]  DP_MASK   = 6'b010100
) (
  input  logic       clk,
  input  logic       hard_reset,
  input  logic [3:0] d,
  input  logic [3:0] e,
  input  logic [3:0] f,
  input  logic [3:0] g,
  input  logic [3:0] h,
  input  logic [3:0] i,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  // Active-low segment pattern (gfedcba) for one BCD digit; codes 10-15 show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

`ifdef SEG_LZ_BLANK_EN
  // Slot k is dark when slots 5..k all hold zero. Slot 0 always stays lit.
  function automatic logic [5:0] lz_mask_f(input logic [23:0] s);
    logic [5:0] m;
    m    = '0;
    m[5] = (s[23:20] == 4'd0);
    for (int k = 4; k >= 1; k--) begin
      m[k] = m[k+1] && (s[4*k +: 4] == 4'd0);
    end
    return m;
  endfunction
`endif

  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] div_cnt_nxt;
  logic [2:0]       idx;
  logic [2:0]       idx_nxt;
  logic [23:0]      snap;
  logic [23:0]      snap_eff;
  logic             snap_now_c;
  logic             in_blank_c;
  logic             lz_blank_c;
  logic [3:0]       digit_c;
  logic [5:0]       an_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;
`ifdef SEG_LZ_BLANK_EN
  logic [5:0]       lz_mask;
  logic [5:0]       lz_eff;
`endif

  // Next scan position, effective snapshot for this cycle and next pin values.
  always_comb begin
    snap_now_c  = (idx == 3'd5) && (div_cnt == '0);
    div_cnt_nxt = (div_cnt == CNT_MAX) ? '0 : div_cnt + CNT_W'(1);
    idx_nxt     = idx;
    if (div_cnt == CNT_MAX) begin
      idx_nxt = (idx == 3'd0) ? 3'd5 : idx - 3'd1;
    end
    // The frame's first slot uses the digits being latched now, so a frame is never mixed.
    snap_eff = snap_now_c ? {d, e, f, g, h, i} : snap;
`ifdef SEG_LZ_BLANK_EN
    lz_eff     = snap_now_c ? lz_mask_f({d, e, f, g, h, i}) : lz_mask;
    lz_blank_c = lz_eff[idx];
`else
    lz_blank_c = 1'b0;
`endif
    case (idx)
      3'd5:    digit_c = snap_eff[23:20];
      3'd4:    digit_c = snap_eff[19:16];
      3'd3:    digit_c = snap_eff[15:12];
      3'd2:    digit_c = snap_eff[11:8];
      3'd1:    digit_c = snap_eff[7:4];
      default: digit_c = snap_eff[3:0];
    endcase
    in_blank_c = (32'(div_cnt) < BLANK_CYC);
    an_nxt     = 6'h3F;
    seg_nxt    = 7'h7F;
    dp_nxt     = 1'b1;
    if (!in_blank_c && !lz_blank_c) begin
      an_nxt  = ~(6'b000001 << idx);
      seg_nxt = seg_decode(digit_c);
      dp_nxt  = ~DP_MASK[idx];
    end
  end

  // Scan state, frame snapshot and registered display pins.
  always_ff @(posedge clk) begin
    if (!hard_reset) begin
      div_cnt     <= '0;
      idx         <= 3'd5;
      snap        <= '0;
`ifdef SEG_LZ_BLANK_EN
      lz_mask     <= '0;
`endif
      an          <= 6'h3F;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= div_cnt_nxt;
      idx         <= idx_nxt;
      snap        <= snap_eff;
`ifdef SEG_LZ_BLANK_EN
      lz_mask     <= lz_eff;
`endif
      an          <= an_nxt;
      seg         <= seg_nxt;
      dp          <= dp_nxt;
      frame_start <= snap_now_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized self-checking bench for seg_scan_driver.
// The reference model derives the expected pins from the cycle count since
// reset release, the scan order and per-frame digit latching.
module tb_seg_scan_driver;

  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned BLANK_CYC = 1;
  localparam logic [5:0]  DP_MASK   = 6'b010100;
  localparam int unsigned FRAME     = 6 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       hard_reset;
  logic [3:0] d, e, f, g, h, i;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: cycles since reset release, plus the latched frame digits.
  int         cyc = 0;
  logic [3:0] m_dig [6];
  logic [6:0] seg_tab [16];

  seg_scan_driver #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC),
    .DP_MASK  (DP_MASK)
  ) dut (
    .clk        (clk),
    .hard_reset (hard_reset),
    .d          (d),
    .e          (e),
    .f          (f),
    .g          (g),
    .h          (h),
    .i          (i),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // A slot is dark under leading-zero suppression when it and every slot to its left hold 0.
  function automatic bit lz_dark(input int slot);
`ifdef SEG_LZ_BLANK_EN
    if (slot == 0) return 1'b0;
    for (int k = 5; k >= slot; k--) begin
      if (m_dig[k] != 4'd0) return 1'b0;
    end
    return 1'b1;
`else
    return (slot < 0);
`endif
  endfunction

  // Advance one clock: predict the pins for this cycle, then compare after the edge.
  task automatic tick();
    logic [5:0] x_an;
    logic [6:0] x_seg;
    logic       x_dp;
    logic       x_fs;
    int         slot;
    int         pos;
    x_an  = 6'h3F;
    x_seg = 7'h7F;
    x_dp  = 1'b1;
    x_fs  = 1'b0;
    if (!hard_reset) begin
      cyc = 0;
    end else begin
      if (cyc % FRAME == 0) begin
        m_dig[5] = d; m_dig[4] = e; m_dig[3] = f;
        m_dig[2] = g; m_dig[1] = h; m_dig[0] = i;
      end
      slot = 5 - ((cyc / SCAN_DIV) % 6);
      pos  = cyc % SCAN_DIV;
      x_fs = (cyc % FRAME == 0);
      if (pos >= BLANK_CYC && !lz_dark(slot)) begin
        x_an  = ~(6'd1 << slot);
        x_seg = seg_tab[m_dig[slot]];
        x_dp  = ~DP_MASK[slot];
      end
      cyc++;
    end
    @(posedge clk);
    #1;
    check("an", 32'(an), 32'(x_an));
    check("seg", 32'(seg), 32'(x_seg));
    check("dp", 32'(dp), 32'(x_dp));
    check("frame_start", 32'(frame_start), 32'(x_fs));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  function automatic logic [3:0] rnd_digit();
    if ($urandom_range(0, 2) == 0) return 4'd0;
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
    for (int k = 10; k < 16; k++) seg_tab[k] = 7'h3F;
    for (int k = 0; k < 6; k++) m_dig[k] = 4'd0;

    // Reset held for three cycles, then the 1..6 digit sweep over two frames.
    hard_reset = 1'b0;
    d = 4'd1; e = 4'd2; f = 4'd3; g = 4'd4; h = 4'd5; i = 4'd6;
    run(3);
    hard_reset = 1'b1;
    run(2 * FRAME);

    // Change i while slot 3 is lit; the current frame must keep the old digit.
    run(9);
    i = 4'd9;
    run(2 * FRAME - 9);

    // Invalid code on slot 2, then leading-zero patterns.
    g = 4'hC;
    run(FRAME);
    d = 4'd0; e = 4'd0; f = 4'd0; g = 4'd1; h = 4'd0; i = 4'd0;
    run(FRAME);
    g = 4'd0;
    run(FRAME);

    // Reset for one cycle while slot 2 is lit.
    run(14);
    d = 4'd7; e = 4'd8; f = 4'd9; g = 4'd2; h = 4'd4; i = 4'd5;
    hard_reset = 1'b0;
    tick();
    hard_reset = 1'b1;
    run(FRAME + 3);

    // Random digit changes at random points, with occasional mid-frame resets.
    for (int n = 0; n < 60; n++) begin
      d = rnd_digit(); e = rnd_digit(); f = rnd_digit();
      g = rnd_digit(); h = rnd_digit(); i = 4'($urandom_range(0, 15));
      run($urandom_range(1, 30));
      if ($urandom_range(0, 7) == 0) begin
        hard_reset = 1'b0;
        run($urandom_range(1, 3));
        hard_reset = 1'b1;
      end
    end
    run(FRAME);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
